// File: rtl/arb_mux_pkg.sv
// Shared limits and select-width helper for the round-robin arbiter mux.
package arb_mux_pkg;

  localparam int MAX_N = 16;
  localparam int MAX_W = 64;

  function automatic int sel_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 6; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr.
module rr_pick import arb_mux_pkg::*; #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt,
  output logic          any
);

  // Walk from the far end so the slot closest to ptr wins last.
  always_comb begin
    int j;
    gnt = '0;
    any = 1'b0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt = SW'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 round-robin arbitrated mux with a one-word output register.
// ARB_MUX_MANUAL_SEL_EN adds man_en/man_sel forced selection.
module arb_mux import arb_mux_pkg::*; #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = sel_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef ARB_MUX_MANUAL_SEL_EN
  input  logic          man_en,
  input  logic [SW-1:0] man_sel,
`endif
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_sel,
  output logic          out_valid,
  input  logic          out_ready
);

  logic          ld;
  logic          gok;
  logic          adv;
  logic          xfer;
  logic          rr_any;
  logic [SW-1:0] rr_g;
  logic [SW-1:0] g;
  logic [SW-1:0] ptr;
  logic [N-1:0]  oh;
  logic [W-1:0]  sel_data;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req (in_valid),
    .ptr (ptr),
    .gnt (rr_g),
    .any (rr_any)
  );

  assign ld = ~out_valid | out_ready;

`ifdef ARB_MUX_MANUAL_SEL_EN
  // Forced selection grants the slot even if it is idle; an
  // out-of-range index grants nothing.
  always_comb begin
    g   = rr_g;
    gok = rr_any;
    adv = 1'b1;
    if (man_en) begin
      g   = man_sel;
      gok = (int'(man_sel) < N);
      adv = 1'b0;
    end
  end
`else
  assign g   = rr_g;
  assign gok = rr_any;
  assign adv = 1'b1;
`endif

  always_comb begin
    oh       = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SW'(i)) begin
        oh[i]    = 1'b1;
        sel_data = in_data[i*W +: W];
      end
    end
  end

  assign in_ready = oh & {N{gok & ld & rst_n}};
  assign xfer     = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (ld) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_sel  <= g;
      end
      if (xfer && adv) begin
        ptr <= (g == SW'(N - 1)) ? '0 : g + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux with a reference model and scoreboard.
module tb_arb_mux;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;
  logic           man_en;
  logic [SW-1:0]  man_sel;

  logic [23:0] d3;
  logic [2:0]  v3;
  logic [2:0]  r3;
  logic [7:0]  od3;
  logic [1:0]  os3;
  logic        ov3;
  logic        ordy3;

  always #5 clk = ~clk;

  arb_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ARB_MUX_MANUAL_SEL_EN
    .man_en    (man_en),
    .man_sel   (man_sel),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  arb_mux #(.N(3), .W(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ARB_MUX_MANUAL_SEL_EN
    .man_en    (1'b0),
    .man_sel   (2'd0),
`endif
    .in_data   (d3),
    .in_valid  (v3),
    .in_ready  (r3),
    .out_data  (od3),
    .out_sel   (os3),
    .out_valid (ov3),
    .out_ready (ordy3)
  );

  typedef struct {
    int sel;
    int data;
  } word_t;

  word_t sb[$];
  int    passed = 0;
  int    total  = 0;
  int    m_ptr  = 0;
  bit    m_valid = 1'b0;
  int    m_sel  = 0;
  int    m_data = 0;
  bit    m_man  = 1'b0;
  int    m_msel = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    sb.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
  endtask

  // One clock: predict grant, check in_ready, then check registered output.
  task automatic cyc();
    int         g;
    bit         ld;
    bit         hit;
    logic [N-1:0] er;
    word_t      w;
    @(negedge clk);
    ld  = !m_valid || out_ready;
    hit = 1'b0;
    g   = 0;
    if (m_man) begin
      if (m_msel < N) begin
        hit = 1'b1;
        g   = m_msel;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!hit && in_valid[j]) begin
          hit = 1'b1;
          g   = j;
        end
      end
    end
    er = '0;
    if (hit && ld) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    if (ld) begin
      if (hit && in_valid[g]) begin
        w.sel  = g;
        w.data = int'(in_data[g*W +: W]);
        sb.push_back(w);
        m_valid = 1'b1;
        if (!m_man) m_ptr = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (sb.size() > 0) begin
      w      = sb.pop_front();
      m_sel  = w.sel;
      m_data = w.data;
    end
    if (m_valid) begin
      chk("out_sel", 32'(out_sel), 32'(m_sel));
      chk("out_data", 32'(out_data), 32'(m_data));
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    man_en    = 1'b0;
    man_sel   = '0;
    d3        = {8'h72, 8'h71, 8'h70};
    v3        = '0;
    ordy3     = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full rotation, one word per cycle.
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    repeat (5) cyc();
    in_valid = 4'b0000;
    cyc();

    // Sparse requesters alternate.
    in_valid = 4'b0101;
    repeat (4) cyc();
    in_valid = 4'b0000;
    cyc();

    // Load 0xA5 then stall the sink for five cycles.
    in_data[15:8] = 8'hA5;
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    cyc();
    chk("hold_word", 32'(out_data), 32'hA5);
    in_valid = 4'b1111;
    repeat (5) cyc();
    chk("hold_after", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    repeat (2) cyc();

    // Asynchronous reset between edges while a word is held.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_sel", 32'(out_sel), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 4'b1000;
    cyc();
    in_valid = 4'b1111;
    cyc();

`ifdef ARB_MUX_MANUAL_SEL_EN
    man_en  = 1'b1;
    man_sel = 2'd2;
    m_man   = 1'b1;
    m_msel  = 2;
    repeat (3) cyc();
    man_en = 1'b0;
    m_man  = 1'b0;
    repeat (2) cyc();
`endif

    // Three-channel instance wraps 2 -> 0.
    v3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("n3_valid", 32'(ov3), 32'd1);
      chk("n3_sel", 32'(os3), 32'(k % 3));
      chk("n3_data", 32'(od3), 32'(8'h70 + k % 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
